// File: rtl/ifetch_queue.sv
// In-order instruction fetch: issues word requests, queues responses with their PCs, presents them to decode.
// Output is a combinational view of the head entry; requests stall when allocated plus to-be-dropped reach DEPTH.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [63:0]      fetch_pc;
  logic [63:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head, fill, tail;
  logic [CW-1:0]    count, pend_cnt, drop_cnt;
  logic [CW:0]      credit_used, drop_on_redirect;
  logic             accept, pop, resp_fill, resp_drop, head_vld;

  always_comb begin
    credit_used    = {1'b0, count} + {1'b0, drop_cnt};
    head_vld       = (count != '0) && !reset;
    imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;
    out_valid      = head_vld && filled_q[head] && !redirect_valid;
    out_pc         = head_vld ? pc_q[head] : '0;
    out_instr      = head_vld ? instr_q[head] : '0;
    pop            = out_valid && out_ready;
    resp_drop      = imem_resp_valid && (drop_cnt != '0);
    resp_fill      = imem_resp_valid && (drop_cnt == '0) && (pend_cnt != '0);
    // Every unfilled entry still owes a response; the one arriving now is consumed by the flush.
    drop_on_redirect = {1'b0, drop_cnt} + {1'b0, pend_cnt};
    if (imem_resp_valid && (drop_on_redirect != '0))
      drop_on_redirect = drop_on_redirect - (CW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      filled_q <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~64'h3;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= drop_on_redirect[CW-1:0];
    end else begin
      if (accept) begin
        filled_q[tail] <= 1'b0;
        tail           <= tail + PW'(1);
        fetch_pc       <= fetch_pc + 64'd4;
      end
      if (resp_fill) begin
        filled_q[fill] <= 1'b1;
        fill           <= fill + PW'(1);
      end
      if (pop)
        head <= head + PW'(1);
      if (resp_drop)
        drop_cnt <= drop_cnt - CW'(1);
      count    <= count + CW'(accept) - CW'(pop);
      pend_cnt <= pend_cnt + CW'(accept) - CW'(resp_fill);
    end
  end

  // Payload storage needs no reset; an entry's instr is zeroed on allocation so an unfilled head reads 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[tail]    <= fetch_pc;
      instr_q[tail] <= '0;
    end
    if (resp_fill && !reset && !redirect_valid)
      instr_q[fill] <= imem_resp_data;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, corner-case sequences, and randomized traffic against a queue model.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h1000;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr, redirect_pc, out_pc;
  logic [31:0] imem_resp_data, out_instr;
  logic        redirect_valid, out_valid, out_ready;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  typedef struct { logic [63:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [63:0] a; int due; } mreq_t;
  typedef struct {
    bit rst; bit rr; bit rsv; logic [31:0] rd; bit rdv; logic [63:0] rpc; bit ordy;
    bit e_rqv; logic [63:0] e_addr; bit e_ov; logic [63:0] e_opc; logic [31:0] e_oi;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  ent_t        mdl[$];
  logic [63:0] m_pc;
  int          m_drop;
  mreq_t       memq[$];
  logic [63:0] acc_q[$], pop_pc[$];
  logic [31:0] pop_in[$];
  int p_rdy, p_resp, p_ordy, p_redir, p_rst, lat_min, lat_max;
  bit track_gap, seen_out;
  int gaps;
  vec_t tv[10];

  function automatic logic [31:0] memf(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF ^ {a[47:32], 16'h0};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); pop_pc.delete(); pop_in.delete();
  endtask

  // Called at the negative edge with inputs stable: compare against the model, then advance it.
  task automatic step();
    logic        e_rqv, e_ov;
    logic [63:0] e_opc;
    logic [31:0] e_oi;
    int          unf, d;
    ent_t        e;
    e_rqv = !reset && !redirect_valid && (mdl.size() + m_drop < DEPTH);
    e_ov  = !reset && !redirect_valid && mdl.size() > 0 && mdl[0].filled;
    e_opc = (!reset && mdl.size() > 0) ? mdl[0].pc : 64'h0;
    e_oi  = (!reset && mdl.size() > 0) ? mdl[0].instr : 32'h0;
    chk("req_valid", 64'(imem_req_valid), 64'(e_rqv));
    if (e_rqv) chk("req_addr", imem_req_addr, m_pc);
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("out_pc", out_pc, e_opc);
    chk("out_instr", 64'(out_instr), 64'(e_oi));
    if (!reset && imem_req_valid && imem_req_ready) begin
      acc_q.push_back(imem_req_addr);
      memq.push_back('{imem_req_addr, cyc + $urandom_range(lat_max, lat_min)});
    end
    if (!reset && out_valid && out_ready) begin
      pop_pc.push_back(out_pc);
      pop_in.push_back(out_instr);
    end
    if (track_gap) begin
      if (out_valid) seen_out = 1'b1;
      else if (seen_out) gaps++;
    end
    if (reset) begin
      mdl.delete(); memq.delete(); m_pc = RPC; m_drop = 0;
    end else if (redirect_valid) begin
      unf = 0;
      foreach (mdl[i]) if (!mdl[i].filled) unf++;
      d = m_drop + unf;
      if (imem_resp_valid && d > 0) d--;
      m_drop = d;
      mdl.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      if (imem_resp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mdl.size(); i++) begin
            if (!mdl[i].filled) begin
              e = mdl[i]; e.instr = imem_resp_data; e.filled = 1'b1; mdl[i] = e;
              break;
            end
          end
        end
      end
      if (e_ov && out_ready) void'(mdl.pop_front());
      if (e_rqv && imem_req_ready) begin
        mdl.push_back('{m_pc, 32'h0, 1'b0});
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  // Memory and decode behaviour for the current cycle, chosen from the knobs.
  task automatic drive();
    reset          = ($urandom_range(999) < p_rst);
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_ordy);
    redirect_valid = ($urandom_range(99) < p_redir);
    case ($urandom_range(2))
      0:       redirect_pc = {$urandom, $urandom};
      1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      default: redirect_pc = 64'($urandom_range(255));
    endcase
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < p_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(memq[0].a);
      void'(memq.pop_front());
    end
  endtask

  task automatic run(int n);
    repeat (n) begin drive(); tick(); end
  endtask

  task automatic redir(logic [63:0] pc);
    drive();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
  endtask

  task automatic set_knobs(int rdy, int resp, int ordy);
    p_rdy = rdy; p_resp = resp; p_ordy = ordy; p_redir = 0; p_rst = 0; lat_min = 1; lat_max = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] at64(logic [63:0] q[$], int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    set_knobs(100, 100, 100);
    m_pc = RPC; m_drop = 0; track_gap = 0; seen_out = 0; gaps = 0;
    do_reset();

    // Redirect landing on a response with one filled and two unfilled entries.
    tv[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 64'h0,    1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    32'h0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 64'h0,    1'b0, 1'b1, 64'h1000, 1'b0, 64'h0,    32'h0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 64'h0,    1'b0, 1'b1, 64'h1004, 1'b0, 64'h1000, 32'h0};
    tv[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 64'h0,    1'b0, 1'b1, 64'h1008, 1'b1, 64'h1000, 32'hAAAA_0001};
    tv[4] = '{1'b0, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1, 64'h2002, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000, 32'hAAAA_0001};
    tv[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 64'h0,    1'b1, 1'b1, 64'h2000, 1'b0, 64'h0,    32'h0};
    tv[6] = '{1'b0, 1'b1, 1'b1, 32'hCCCC_0003, 1'b0, 64'h0,    1'b1, 1'b1, 64'h2000, 1'b0, 64'h0,    32'h0};
    tv[7] = '{1'b0, 1'b0, 1'b1, 32'hDDDD_0004, 1'b0, 64'h0,    1'b1, 1'b1, 64'h2004, 1'b0, 64'h2000, 32'h0};
    tv[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 64'h0,    1'b1, 1'b1, 64'h2004, 1'b1, 64'h2000, 32'hDDDD_0004};
    tv[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 64'h0,    1'b1, 1'b1, 64'h2004, 1'b0, 64'h0,    32'h0};
    for (int i = 0; i < 10; i++) begin
      reset = tv[i].rst; imem_req_ready = tv[i].rr; imem_resp_valid = tv[i].rsv; imem_resp_data = tv[i].rd;
      redirect_valid = tv[i].rdv; redirect_pc = tv[i].rpc; out_ready = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("tv%0d_req_valid", i), 64'(imem_req_valid), 64'(tv[i].e_rqv));
      if (tv[i].e_rqv) chk($sformatf("tv%0d_req_addr", i), imem_req_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_out_valid", i), 64'(out_valid), 64'(tv[i].e_ov));
      chk($sformatf("tv%0d_out_pc", i), out_pc, tv[i].e_opc);
      chk($sformatf("tv%0d_out_instr", i), 64'(out_instr), 64'(tv[i].e_oi));
      step();
    end

    // Steady stream: back-to-back requests and gap-free output.
    do_reset(); set_knobs(100, 100, 100); clear_logs();
    track_gap = 1; seen_out = 0; gaps = 0;
    run(30);
    track_gap = 0;
    for (int i = 0; i < 8; i++) begin
      chk("steady_addr", at64(acc_q, i), RPC + 64'(4 * i));
      chk("steady_pop_pc", at64(pop_pc, i), RPC + 64'(4 * i));
      chk("steady_pop_instr", (i < pop_in.size()) ? 64'(pop_in[i]) : 64'hDEAD, 64'(memf(RPC + 64'(4 * i))));
    end
    chk("steady_gaps", 64'(gaps), 64'h0);
    chk("steady_pop_count", 64'(pop_pc.size()), 64'd28);

    // Full queue with decode stalled, then drain.
    do_reset(); set_knobs(100, 100, 0);
    redir(64'h0); clear_logs();
    run(12);
    chk("full_accepts", 64'(acc_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("full_addr", at64(acc_q, i), 64'(4 * i));
    chk("full_req_valid", 64'(imem_req_valid), 64'h0);
    p_ordy = 100; clear_logs();
    run(12);
    for (int i = 0; i < 4; i++) chk("drain_pc", at64(pop_pc, i), 64'(4 * i));
    chk("drain_resume_addr", at64(acc_q, 0), 64'h10);

    // Redirect with three requests outstanding.
    do_reset(); set_knobs(100, 0, 100);
    run(3);
    chk("outstanding3", 64'(acc_q.size() >= 3), 64'h1);
    redir(64'h2002); clear_logs(); p_resp = 100;
    run(15);
    chk("redir_addr", at64(acc_q, 0), 64'h2000);
    chk("redir_pop_pc", at64(pop_pc, 0), 64'h2000);
    chk("redir_pop_instr", (pop_in.size() > 0) ? 64'(pop_in[0]) : 64'hDEAD, 64'(memf(64'h2000)));

    // Fetch PC wrapping through zero.
    do_reset(); set_knobs(100, 100, 100);
    redir(64'hFFFF_FFFF_FFFF_FFFE); clear_logs();
    run(10);
    chk("wrap_addr0", at64(acc_q, 0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr1", at64(acc_q, 1), 64'h0);
    chk("wrap_pop0", at64(pop_pc, 0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pop1", at64(pop_pc, 1), 64'h0);
    chk("wrap_instr1", (pop_in.size() > 1) ? 64'(pop_in[1]) : 64'hDEAD, 64'(memf(64'h0)));

    // Reset in the middle of a full queue.
    do_reset(); set_knobs(100, 100, 0);
    run(10);
    chk("pre_rst_out_valid", 64'(out_valid), 64'h1);
    chk("pre_rst_req_valid", 64'(imem_req_valid), 64'h0);
    drive(); reset = 1'b1; #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    tick();
    reset = 1'b0; p_ordy = 100; clear_logs();
    drive(); #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'h0);
    tick();
    run(5);
    chk("post_rst_addr", at64(acc_q, 0), RPC);

    // Randomized traffic with redirects and occasional resets.
    do_reset(); set_knobs(70, 60, 60);
    p_redir = 3; p_rst = 2; lat_min = 1; lat_max = 4;
    run(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
